// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and sizing helpers for the serial subtractor
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must hold WIDTH-1; a 1-bit counter is kept even for WIDTH=1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_from_half.sv
// rtl/full_subtractor_from_half.sv - 1-bit full subtractor built from two half subtractors
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_subtractor_from_half (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.x(a),  .y(b),   .d(d1), .bo(b1));
  half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .bo(b2));

  assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt, d_msb;
  logic             brw_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fs_d, fs_bo;

  full_subtractor_from_half u_fs (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (brw_q),
    .d   (fs_d),
    .bo  (fs_bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // New bit enters at the MSB; written as shift-or so WIDTH=1 needs no special case.
  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = fs_d;
    res_nxt          = (res_sr >> 1) | d_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      brw_q      <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw_q <= bin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          brw_q  <= fs_bo;
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff       <= res_nxt;
            borrow_out <= fs_bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed bench for serial_subtractor at WIDTH=8 and WIDTH=1
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       start8, bin8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start1, a1, b1, bin1, busy1, done1, diff1, bo1;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                     input string tag, input logic [7:0] ed, input logic ebo);
    int         n, bc;
    logic [7:0] prev_d;
    logic       prev_bo;
    @(negedge clk);
    prev_d = diff8; prev_bo = bo8;
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk({tag, " hold_diff"}, diff8, prev_d);
    chk({tag, " hold_borrow"}, bo8, prev_bo);
    n = 0; bc = 0;
    while (n < 40) begin
      if (busy8) bc++;
      if (done8) break;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, 8);
    chk({tag, " busy_cycles"}, bc, 9);
    chk({tag, " diff"}, diff8, ed);
    chk({tag, " borrow"}, bo8, ebo);
    @(negedge clk);
    chk({tag, " done_pulse"}, done8, 1'b0);
    chk({tag, " idle"}, busy8, 1'b0);
  endtask

  task automatic op1(input logic ia, input logic ib, input logic ibin,
                     input logic ed, input logic ebo);
    int n;
    @(negedge clk);
    a1 = ia; b1 = ib; bin1 = ibin; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (n < 10) begin
      if (done1) break;
      @(negedge clk);
      n++;
    end
    chk($sformatf("w1 %0b%0b%0b latency", ia, ib, ibin), n, 1);
    chk($sformatf("w1 %0b%0b%0b diff", ia, ib, ibin), diff1, ed);
    chk($sformatf("w1 %0b%0b%0b borrow", ia, ib, ibin), bo1, ebo);
    @(negedge clk);
    chk("w1 done_pulse", done1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k, n, r;
    logic       saw_idle, chain_b;
    logic [7:0] exp_d [2];
    logic       exp_bo[2];

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h27, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
    vecs[7] = '{8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy8", busy8, 1'b0);
    chk("reset done8", done8, 1'b0);
    chk("reset diff8", diff8, 8'h00);
    chk("reset borrow8", bo8, 1'b0);
    chk("reset busy1", busy1, 1'b0);
    chk("reset diff1", diff1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), vecs[i].d, vecs[i].bo);

    // 16-bit 0x0100 - 0x0001 as two chained words
    op8(8'h00, 8'h01, 1'b0, "chain_lo", 8'hFF, 1'b1);
    chain_b = bo8;
    op8(8'h01, 8'h00, chain_b, "chain_hi", 8'h00, 1'b0);

    // start held high, operands scrambled while busy
    exp_d[0] = 8'h27; exp_bo[0] = 1'b0;
    exp_d[1] = 8'hFF; exp_bo[1] = 1'b1;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; bin8 = 1'b0; start8 = 1'b1;
    k = 0; n = 0; saw_idle = 1'b0;
    while (k < 2 && n < 60) begin
      @(negedge clk);
      n++;
      if (done8) begin
        chk($sformatf("held_start diff%0d", k), diff8, exp_d[k]);
        chk($sformatf("held_start borrow%0d", k), bo8, exp_bo[k]);
        k++;
      end
      if (!busy8) begin
        saw_idle = 1'b1;
        a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
    chk("held_start results", k, 2);
    chk("held_start idle_gap", saw_idle, 1'b1);
    @(negedge clk);
    chk("held_start end_idle", busy8, 1'b0);

    // asynchronous reset with cnt=3, off the clock edge
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst busy", busy8, 1'b0);
    chk("async_rst done", done8, 1'b0);
    chk("async_rst diff", diff8, 8'h00);
    chk("async_rst borrow", bo8, 1'b0);
    @(negedge clk);
    chk("async_rst held", busy8, 1'b0);
    rst = 1'b0;
    op8(8'h5A, 8'h33, 1'b0, "post_rst", 8'h27, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r = int'(i[2]) - int'(i[1]) - int'(i[0]);
      op1(i[2], i[1], i[0], 1'((r % 2) != 0), r < 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
